// File: rtl/ysyx_23060077_wbu_pkg.sv
// Shared widths, state encodings and the buffered entry layout for the writeback unit.
package ysyx_23060077_wbu_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(4);

  typedef enum logic {
    WBU_ST_RUN   = 1'b0,
    WBU_ST_REDIR = 1'b1
  } wbu_state_e;

  // One execute-stage result as held in the input FIFO
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     result;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     src1;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rd_wen;
    logic                      branch;
    logic                      jal;
    logic                      jalr;
  } wbu_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(wbu_entry_t);

endpackage

// File: rtl/ysyx_23060077_wbu_fifo.sv
// Small synchronous FIFO with flush; flush wins over a same-cycle push.
module ysyx_23060077_wbu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ysyx_23060077_wbu.sv
// Writeback/commit unit: buffers execute results, resolves next PC, writes rd, redirects fetch.
// Optional target misalignment check: YSYX_23060077_WBU_MISALIGN_CHECK_EN.
module ysyx_23060077_wbu
  import ysyx_23060077_wbu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [DATA_WIDTH-1:0]     in_src1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic                      in_branch,
  input  logic                      in_jal,
  input  logic                      in_jalr,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      redirect_valid,
  input  logic                      redirect_ready,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      commit_valid,
  output logic [DATA_WIDTH-1:0]     commit_pc,
  output logic [DATA_WIDTH-1:0]     commit_next_pc,
  output logic                      misalign_exc,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  wbu_state_e                state, state_n;
  wbu_entry_t                in_entry, head;
  logic                      push, pop, flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [DATA_WIDTH-1:0]     seq_pc, next_pc;
  logic                      ctrl_change, misaligned;

  logic                      rf_wen_n, redirect_valid_n, commit_valid_n, misalign_n;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_n;
  logic [DATA_WIDTH-1:0]     rf_wdata_n, redirect_pc_n, commit_pc_n, commit_next_pc_n;

  assign in_entry = '{pc: in_pc, result: in_result, imm: in_imm, src1: in_src1,
                      rd: in_rd, rd_wen: in_rd_wen, branch: in_branch,
                      jal: in_jal, jalr: in_jalr};

  assign in_ready = (state == WBU_ST_RUN) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == WBU_ST_RUN) && !fifo_empty;
  assign busy     = (fifo_count != '0) || (state == WBU_ST_REDIR);

  ysyx_23060077_wbu_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-PC resolution for the head entry
  always_comb begin
    seq_pc = head.pc + PC_INC;
    if (head.jalr)                        next_pc = (head.src1 + head.imm) & ~DATA_WIDTH'(1);
    else if (head.jal)                    next_pc = head.pc + head.imm;
    else if (head.branch && head.result[0]) next_pc = head.pc + head.imm;
    else                                  next_pc = seq_pc;
  end

  assign ctrl_change = (next_pc != seq_pc);

`ifdef YSYX_23060077_WBU_MISALIGN_CHECK_EN
  assign misaligned = ctrl_change && (next_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Any control-flow change drops the wrong-path entries behind it
  assign flush = pop && ctrl_change;

  always_comb begin
    state_n          = state;
    rf_wen_n         = 1'b0;
    rf_waddr_n       = rf_waddr;
    rf_wdata_n       = rf_wdata;
    redirect_valid_n = redirect_valid;
    redirect_pc_n    = redirect_pc;
    commit_valid_n   = 1'b0;
    commit_pc_n      = commit_pc;
    commit_next_pc_n = commit_next_pc;
    misalign_n       = 1'b0;
    case (state)
      WBU_ST_RUN: begin
        if (pop) begin
          rf_wen_n         = head.rd_wen && (head.rd != '0) && !head.branch && !misaligned;
          rf_waddr_n       = head.rd;
          rf_wdata_n       = head.result;
          commit_valid_n   = 1'b1;
          commit_pc_n      = head.pc;
          commit_next_pc_n = next_pc;
          misalign_n       = misaligned;
          if (ctrl_change && !misaligned) begin
            redirect_valid_n = 1'b1;
            redirect_pc_n    = next_pc;
            state_n          = WBU_ST_REDIR;
          end
        end
      end
      WBU_ST_REDIR: begin
        if (redirect_ready) begin
          redirect_valid_n = 1'b0;
          state_n          = WBU_ST_RUN;
        end
      end
      default: state_n = WBU_ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= WBU_ST_RUN;
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      commit_valid   <= 1'b0;
      commit_pc      <= '0;
      commit_next_pc <= '0;
      misalign_exc   <= 1'b0;
    end else begin
      state          <= state_n;
      rf_wen         <= rf_wen_n;
      rf_waddr       <= rf_waddr_n;
      rf_wdata       <= rf_wdata_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      commit_valid   <= commit_valid_n;
      commit_pc      <= commit_pc_n;
      commit_next_pc <= commit_next_pc_n;
      misalign_exc   <= misalign_n;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_wbu.sv
// Scoreboard bench for ysyx_23060077_wbu: directed vectors, expected commits/redirects queued.
module tb_ysyx_23060077_wbu;
  import ysyx_23060077_wbu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_result, in_imm, in_src1;
  logic [4:0]  in_rd;
  logic        in_rd_wen, in_branch, in_jal, in_jalr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_next_pc;
  logic        misalign_exc, busy;

  always #5 clock = ~clock;

  ysyx_23060077_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_imm(in_imm), .in_src1(in_src1),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_branch(in_branch),
    .in_jal(in_jal), .in_jalr(in_jalr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
    .misalign_exc(misalign_exc), .busy(busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
  } exp_commit_t;

  exp_commit_t cq[$];
  logic [31:0] rq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_c(input logic [31:0] pc, input logic [31:0] npc, input logic wen,
                       input logic [4:0] waddr, input logic [31:0] wdata, input logic mis);
    exp_commit_t e;
    e.pc = pc; e.next_pc = npc; e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.mis = mis;
    cq.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a commit or a new redirect
  exp_commit_t mon_e;
  logic        prev_rv;
  logic [31:0] prev_rpc;
  always @(negedge clock) begin
    if (reset) begin
      prev_rv  <= 1'b0;
      prev_rpc <= '0;
    end else begin
      if (commit_valid) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got pc %h expected no commit", commit_pc);
        end else begin
          mon_e = cq.pop_front();
          check("commit_pc", 64'(commit_pc), 64'(mon_e.pc));
          check("commit_next_pc", 64'(commit_next_pc), 64'(mon_e.next_pc));
          check("rf_wen", 64'(rf_wen), 64'(mon_e.wen));
          check("misalign_exc", 64'(misalign_exc), 64'(mon_e.mis));
          if (mon_e.wen) begin
            check("rf_waddr", 64'(rf_waddr), 64'(mon_e.waddr));
            check("rf_wdata", 64'(rf_wdata), 64'(mon_e.wdata));
          end
        end
      end
      if (redirect_valid && !prev_rv) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
        end else begin
          check("redirect_pc", 64'(redirect_pc), 64'(rq.pop_front()));
        end
      end
      if (redirect_valid && prev_rv) check("redirect_hold", 64'(redirect_pc), 64'(prev_rpc));
      prev_rv  <= redirect_valid;
      prev_rpc <= redirect_pc;
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] result, input logic [31:0] imm,
                      input logic [31:0] src1, input logic [4:0] rd, input logic rd_wen,
                      input logic branch, input logic jal, input logic jalr, output int stalls);
    @(negedge clock);
    in_pc = pc; in_result = result; in_imm = imm; in_src1 = src1; in_rd = rd;
    in_rd_wen = rd_wen; in_branch = branch; in_jal = jal; in_jalr = jalr;
    in_valid = 1'b1;
    stalls = 0;
    while (!in_ready && stalls < 100) begin
      @(negedge clock);
      stalls++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for pc %h", pc);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_rv(input logic lvl, input string name);
    int n = 0;
    while (redirect_valid !== lvl && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (redirect_valid !== lvl) begin
      checks++; errors++;
      $display("FAIL %s: got redirect_valid %b expected %b (timeout)", name, redirect_valid, lvl);
    end
  endtask

  int st;

  initial begin
    reset = 1'b1; in_valid = 1'b0; redirect_ready = 1'b1;
    in_pc = '0; in_result = '0; in_imm = '0; in_src1 = '0; in_rd = '0;
    in_rd_wen = 1'b0; in_branch = 1'b0; in_jal = 1'b0; in_jalr = 1'b0;

    #12;
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock) reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // sequential addi
    exp_c(32'h8000_0000, 32'h8000_0004, 1'b1, 5'd5, 32'h12, 1'b0);
    send(32'h8000_0000, 32'h12, 32'h12, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, st);
    repeat (3) @(negedge clock);

    // taken branch; the entry right behind it is flushed
    exp_c(32'h8000_0010, 32'h8000_0030, 1'b0, 5'd3, 32'h1, 1'b0);
    rq.push_back(32'h8000_0030);
    send(32'h8000_0010, 32'h1, 32'h20, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, st);
    send(32'h8000_0014, 32'h99, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, st);
    wait_rv(1'b1, "branch_redirect");
    wait_rv(1'b0, "branch_release");
    @(negedge clock);
    check("branch_busy_after", 64'(busy), 64'd0);
    check("branch_ready_after", 64'(in_ready), 64'd1);

    // jalr with fetch stalling the redirect for three cycles
    redirect_ready = 1'b0;
    exp_c(32'h8000_0100, 32'h8000_1006, 1'b1, 5'd1, 32'h8000_0104, 1'b0);
    rq.push_back(32'h8000_1006);
    send(32'h8000_0100, 32'h8000_0104, 32'h4, 32'h8000_1003, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, st);
    wait_rv(1'b1, "jalr_redirect");
    check("jalr_in_ready_redir", 64'(in_ready), 64'd0);
    check("jalr_busy_redir", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("jalr_held", 64'(redirect_valid), 64'd1);
    end
    redirect_ready = 1'b1;
    @(negedge clock);
    check("jalr_released", 64'(redirect_valid), 64'd0);
    check("jalr_ready_after", 64'(in_ready), 64'd1);
    check("jalr_busy_after", 64'(busy), 64'd0);

    // back-to-back pushes, no stalls expected; rd=0 never writes
    exp_c(32'h8000_2000, 32'h8000_2004, 1'b1, 5'd6, 32'hA, 1'b0);
    exp_c(32'h8000_2004, 32'h8000_2008, 1'b0, 5'd0, 32'hB, 1'b0);
    exp_c(32'h8000_2008, 32'h8000_200C, 1'b1, 5'd7, 32'hC, 1'b0);
    send(32'h8000_2000, 32'hA, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("bp_stall0", 64'(st), 64'd0);
    send(32'h8000_2004, 32'hB, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("bp_stall1", 64'(st), 64'd0);
    send(32'h8000_2008, 32'hC, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
    check("bp_stall2", 64'(st), 64'd0);
    repeat (3) @(negedge clock);

    // not-taken branch and taken branch to pc+4: neither redirects
    exp_c(32'h8000_0200, 32'h8000_0204, 1'b0, 5'd0, 32'h0, 1'b0);
    exp_c(32'h8000_0300, 32'h8000_0304, 1'b0, 5'd0, 32'h1, 1'b0);
    send(32'h8000_0200, 32'h0, 32'h40, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    send(32'h8000_0300, 32'h1, 32'h4, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    repeat (3) @(negedge clock);
    check("nr_redirect_idle", 64'(redirect_valid), 64'd0);

    // jal to a halfword-aligned target
`ifdef YSYX_23060077_WBU_MISALIGN_CHECK_EN
    exp_c(32'h8000_0000, 32'h8000_0006, 1'b0, 5'd1, 32'h8000_0004, 1'b1);
`else
    exp_c(32'h8000_0000, 32'h8000_0006, 1'b1, 5'd1, 32'h8000_0004, 1'b0);
    rq.push_back(32'h8000_0006);
`endif
    send(32'h8000_0000, 32'h8000_0004, 32'h6, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, st);
    repeat (5) @(negedge clock);
    check("jal_redirect_done", 64'(redirect_valid), 64'd0);

    // reset asserted while a redirect is pending
    redirect_ready = 1'b0;
    exp_c(32'h8000_3000, 32'h8000_3100, 1'b0, 5'd0, 32'h8000_3004, 1'b0);
    rq.push_back(32'h8000_3100);
    send(32'h8000_3000, 32'h8000_3004, 32'h100, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, st);
    wait_rv(1'b1, "rst_redir_setup");
    #2 reset = 1'b1;
    #1;
    check("midrst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("midrst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("midrst_commit_pc", 64'(commit_pc), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    redirect_ready = 1'b1;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    check("postrst_busy", 64'(busy), 64'd0);

    repeat (5) @(negedge clock);
    check("commit_queue_drained", 64'(cq.size()), 64'd0);
    check("redirect_queue_drained", 64'(rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
